// File: rtl/timer_digit_entry.sv
// Keypad digit entry for the mm:ss countdown chain: shifts BCD digits in,
// validates on start, issues an active-low preset strobe and holds until done.
module timer_digit_entry #(
  parameter logic [3:0] KEY_CLEAR = 4'hA,
  parameter logic [3:0] KEY_START = 4'hB
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_done,
  output logic [3:0] sec_units,
  output logic [3:0] sec_tens,
  output logic [3:0] min_units,
  output logic [3:0] min_tens,
  output logic       load,
  output logic       busy,
  output logic       err,
  output logic [2:0] digit_cnt
);

  localparam int unsigned DW   = 4;
  localparam int unsigned CW   = 3;
  localparam logic [CW-1:0] CNT_MAX = CW'(4);
  localparam logic [DW-1:0] MAX_SEC_TENS = DW'(5);
  localparam logic [DW-1:0] MAX_DIGIT    = DW'(9);

  typedef enum logic [1:0] {IDLE, ENTRY, COMMIT, ARMED} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] su_d, st_d, mu_d, mt_d;
  logic [CW-1:0] cnt_d;
  logic          load_d, busy_d, err_d;
  logic          is_digit, is_clear, is_start, entry_ok;

  // Key decode and start validation against the current entry register.
  always_comb begin
    is_digit = key_valid && (key_code <= MAX_DIGIT);
    is_clear = key_valid && (key_code == KEY_CLEAR);
    is_start = key_valid && (key_code == KEY_START);
    entry_ok = (sec_tens <= MAX_SEC_TENS) &&
               ({min_tens, min_units, sec_tens, sec_units} != '0);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    su_d    = sec_units;
    st_d    = sec_tens;
    mu_d    = min_units;
    mt_d    = min_tens;
    cnt_d   = digit_cnt;
    load_d  = 1'b1;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (is_digit) begin
          mt_d    = min_units;
          mu_d    = sec_tens;
          st_d    = sec_units;
          su_d    = key_code;
          cnt_d   = CW'(1);
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (is_digit) begin
          if (digit_cnt < CNT_MAX) begin
            mt_d  = min_units;
            mu_d  = sec_tens;
            st_d  = sec_units;
            su_d  = key_code;
            cnt_d = digit_cnt + CW'(1);
          end
        end else if (is_clear) begin
          {mt_d, mu_d, st_d, su_d} = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (is_start) begin
          if (entry_ok) begin
            load_d  = 1'b0;
            state_d = COMMIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = ARMED;
      end
      ARMED: begin
        // timer_done takes priority; a simultaneous clear is simply absorbed.
        if (timer_done || is_clear) begin
          {mt_d, mu_d, st_d, su_d} = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ARMED);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clearn) begin
      state_q   <= IDLE;
      sec_units <= '0;
      sec_tens  <= '0;
      min_units <= '0;
      min_tens  <= '0;
      digit_cnt <= '0;
      load      <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_units <= su_d;
      sec_tens  <= st_d;
      min_units <= mu_d;
      min_tens  <= mt_d;
      digit_cnt <= cnt_d;
      load      <= load_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_timer_digit_entry.sv
// Self-checking bench for timer_digit_entry: queue-based entry model,
// per-cycle output compare, directed scenarios and randomized keys.
module tb_timer_digit_entry;

  localparam logic [3:0] K_CLR = 4'hA;
  localparam logic [3:0] K_STA = 4'hB;

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       timer_done = 1'b0;
  logic [3:0] sec_units, sec_tens, min_units, min_tens;
  logic       load, busy, err;
  logic [2:0] digit_cnt;

  int checks = 0;
  int errors = 0;

  timer_digit_entry #(.KEY_CLEAR(K_CLR), .KEY_START(K_STA)) dut (
    .clk(clk), .clearn(clearn), .key_valid(key_valid), .key_code(key_code),
    .timer_done(timer_done), .sec_units(sec_units), .sec_tens(sec_tens),
    .min_units(min_units), .min_tens(min_tens), .load(load), .busy(busy),
    .err(err), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: entered digits as a queue (newest last), plus a mode.
  // mode: 0 idle, 1 entry, 2 committing, 3 armed.
  int   m_q[$];
  int   m_mode = 0;
  logic m_load = 1'b1, m_busy = 1'b0, m_err = 1'b0;
  bit   m_valid = 0;

  function automatic int dig(int pos);
    if (m_q.size() > pos) return m_q[m_q.size() - 1 - pos];
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!clearn) begin
      m_q.delete();
      m_mode = 0; m_load = 1'b1; m_busy = 1'b0; m_err = 1'b0;
      m_valid = 1;
    end else begin
      bit kd, kc, ks;
      kd = key_valid && (key_code < 10);
      kc = key_valid && (key_code == K_CLR);
      ks = key_valid && (key_code == K_STA);
      m_load = 1'b1;
      m_err  = 1'b0;
      case (m_mode)
        0: if (kd) begin m_q.push_back(int'(key_code)); m_mode = 1; end
        1: begin
          if (kd) begin
            if (m_q.size() < 4) m_q.push_back(int'(key_code));
          end else if (kc) begin
            m_q.delete(); m_mode = 0;
          end else if (ks) begin
            if (dig(1) > 5 || (dig(0) + dig(1) + dig(2) + dig(3)) == 0) m_err = 1'b1;
            else begin m_load = 1'b0; m_mode = 2; end
          end
        end
        2: begin m_mode = 3; m_busy = 1'b1; end
        default: if (timer_done || kc) begin m_q.delete(); m_mode = 0; m_busy = 1'b0; end
      endcase
    end
  end

  // Per-cycle compare plus load/err invariants.
  logic prev_load = 1'b1;
  always @(negedge clk) begin
    if (m_valid) begin
      chk("outputs",
          {12'h0, min_tens, min_units, sec_tens, sec_units, load, busy, err, digit_cnt},
          {12'h0, 4'(dig(3)), 4'(dig(2)), 4'(dig(1)), 4'(dig(0)),
           m_load, m_busy, m_err, 3'(m_q.size())});
      chk("load_twice_low", 32'(!load && !prev_load), 32'h0);
      chk("err_with_load", 32'(err && !load), 32'h0);
      prev_load = load;
    end
  end

  task automatic step(input logic kv, input logic [3:0] kc, input logic td, input logic rn);
    @(negedge clk); #1;
    key_valid = kv; key_code = kc; timer_done = td; clearn = rn;
    @(posedge clk); #1;
  endtask

  task automatic key(input logic [3:0] kc);
    step(1'b1, kc, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  function automatic logic [15:0] digs();
    return {min_tens, min_units, sec_tens, sec_units};
  endfunction

  initial begin
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("reset_digits", 32'(digs()), 32'h0);
    chk("reset_ctl", {28'h0, load, busy, err, 1'b0}, {28'h0, 4'b1000});
    chk("reset_cnt", 32'(digit_cnt), 32'h0);

    // Fill all four positions, then a fifth digit is ignored.
    key(4'd1); key(4'd2); key(4'd3); key(4'd0);
    chk("fill4_digits", 32'(digs()), 32'h1230);
    chk("fill4_cnt", 32'(digit_cnt), 32'd4);
    key(4'd7);
    chk("fifth_ignored", 32'(digs()), 32'h1230);
    key(K_CLR);
    chk("clear_cnt", 32'(digit_cnt), 32'd0);

    // Valid commit and completion.
    key(4'd2); key(4'd4); key(4'd5); key(K_STA);
    chk("commit_load", 32'(load), 32'd0);
    chk("commit_digits", 32'(digs()), 32'h0245);
    idle();
    chk("armed_busy", {30'h0, load, busy}, 32'h3);
    step(1'b0, 4'h0, 1'b1, 1'b1);
    chk("done_idle", {12'h0, digs(), 3'h0, busy, 1'b0, digit_cnt}, 32'h0);

    // Rejected start: sec_tens = 7.
    key(4'd1); key(4'd7); key(4'd0); key(K_STA);
    chk("bad_err", {30'h0, err, load}, 32'h3);
    chk("bad_held", 32'(digs()), 32'h0170);
    idle();
    chk("err_one_cycle", 32'(err), 32'd0);
    key(K_CLR);
    chk("bad_clear_cnt", 32'(digit_cnt), 32'd0);

    // Start in IDLE does nothing; all-zero entry is rejected.
    key(K_STA);
    chk("idle_start", {30'h0, err, load}, 32'h1);
    key(4'd0); key(4'd0);
    chk("zeros_cnt", 32'(digit_cnt), 32'd2);
    key(K_STA);
    chk("zeros_err", {30'h0, err, load}, 32'h3);
    key(K_CLR);

    // Armed: digit ignored, clear+done together, unused code.
    key(4'd3); key(4'd0); key(K_STA); idle();
    chk("armed_0030", 32'(digs()), 32'h0030);
    key(4'd9);
    chk("armed_digit_ign", {15'h0, digs(), busy}, {15'h0, 16'h0030, 1'b1});
    step(1'b1, K_CLR, 1'b1, 1'b1);
    chk("clr_done_idle", {15'h0, digs(), busy}, 32'h0);
    key(4'hE);
    chk("unused_code", {28'h0, 1'b0, digit_cnt}, 32'h0);

    // Reset during the commit cycle.
    key(4'd1); key(4'd2); key(K_STA);
    chk("pre_rst_load", 32'(load), 32'd0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("rst_commit", {12'h0, digs(), load, busy, err, 1'b0, digit_cnt},
        {12'h0, 16'h0, 1'b1, 3'b000, 3'b000});
    idle(); idle();
    chk("rst_no_armed", 32'(busy), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic kv, td, rn;
      logic [3:0] kc;
      kv = ($urandom_range(0, 2) == 0);
      kc = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
      td = ($urandom_range(0, 11) == 0);
      rn = ($urandom_range(0, 149) != 0);
      step(kv, kc, td, rn);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_digit_entry.md
Name: timer_digit_entry

Overview:
- Keypad-side producer for the mm:ss countdown chain; the writer that feeds preset values into the mod-10/mod-6 down counters.
- Accepts one key strobe at a time and shifts decimal digits into a four-digit BCD entry register (min_tens, min_units, sec_tens, sec_units).
- On a start key it validates the entry, then drives the parallel preset bus and an active-low load strobe to the counters.
- Holds the preset stable until the countdown chain reports completion.

Parameters:
- KEY_CLEAR, 4'hA, key code that clears the entry or aborts an armed countdown.
- KEY_START, 4'hB, key code that validates and commits the entry.

Ports:
- clk  input  1  system clock; all logic on posedge.
- clearn  input  1  synchronous active-low reset.
- key_valid  input  1  one-cycle strobe; key_code is valid in this cycle.
- key_code  input  4  0-9 = digit; KEY_CLEAR; KEY_START; all other codes ignored.
- timer_done  input  1  level/pulse from the countdown chain; all digits have reached zero.
- sec_units  output  4  BCD preset for the seconds-units counter.
- sec_tens  output  4  BCD preset for the seconds-tens counter.
- min_units  output  4  BCD preset for the minutes-units counter.
- min_tens  output  4  BCD preset for the minutes-tens counter.
- load  output  1  active-low preset strobe to the counters; low for exactly one cycle per commit.
- busy  output  1  high while a committed countdown is in progress (state ARMED).
- err  output  1  one-cycle pulse on a rejected start.
- digit_cnt  output  3  number of digits entered, 0-4.

Behaviour:
- Reset (clearn=0 at posedge), from any state including mid-commit:
  - state IDLE; all four digit outputs 4'h0; load=1; busy=0; err=0; digit_cnt=0.
- Registered outputs: every output changes only on posedge clk. Key-to-output latency is 1 cycle.
- States: IDLE, ENTRY, COMMIT, ARMED.
- IDLE:
  - key_valid with a digit d (0-9): shift in d, digit_cnt=1, go to ENTRY.
  - KEY_CLEAR, KEY_START or an unused code: no effect.
- ENTRY, digit key:
  - If digit_cnt<4: shift left one BCD position (min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=d) and increment digit_cnt.
  - If digit_cnt=4: key ignored and the register is unchanged.
  - Leading zero digits count toward digit_cnt.
- ENTRY, KEY_CLEAR: digits zeroed, digit_cnt=0, go to IDLE.
- ENTRY, KEY_START:
  - If sec_tens>5, or all four digits are zero: err=1 for one cycle, remain in ENTRY, register unchanged.
  - Otherwise go to COMMIT.
- COMMIT:
  - load=0 for this single cycle; digit outputs stable.
  - Any key arriving in this cycle is dropped.
  - Next state ARMED.
- ARMED:
  - busy=1; digit outputs held stable; digit and start keys ignored.
  - KEY_CLEAR: abort; digits zeroed, digit_cnt=0, busy=0, go to IDLE. No load pulse is issued.
  - timer_done=1: digits zeroed, digit_cnt=0, go to IDLE.
  - timer_done and key_valid in the same cycle: timer_done wins and the key is dropped.
- timer_done is ignored in IDLE, ENTRY and COMMIT.
- load is never low in two consecutive cycles. load is never low while clearn=0.
- The err pulse and the load pulse are mutually exclusive.
- No arithmetic beyond the 3-bit digit_cnt increment, which saturates at 4. BCD digits are only stored, never modified.

Test Plan:
- Reset then keys 1,2,3,0 → min_tens=1, min_units=2, sec_tens=3, sec_units=0, digit_cnt=4; a fifth key 7 leaves the register unchanged.
- Keys 2,4,5 then KEY_START → COMMIT on the next cycle with load=0 for exactly 1 cycle and outputs 0,2,4,5; then busy=1; timer_done → IDLE with all digits 0.
- Keys 1,7,0 then KEY_START (sec_tens=7) → err=1 for one cycle, load stays 1, state ENTRY; KEY_CLEAR → IDLE with digit_cnt=0.
- KEY_START in IDLE, and keys 0,0,KEY_START → no load pulse; err pulses only in the ENTRY case.
- ARMED with outputs 0,0,3,0: digit 9 ignored; KEY_CLEAR and timer_done in the same cycle → IDLE via timer_done; an unused code 4'hE → no effect.
- clearn=0 asserted in the COMMIT cycle → load=1 at that edge, state IDLE, all outputs zero.
